ps2_keyboard: RTL and testbench
===============================

# ps2_keyboard

Receives the PS/2 keyboard serial stream (ps2_clk/ps2_data) and turns each valid 11-bit frame into a scan-code byte. It keeps the two most recent bytes on `key_press`, with the newest in [7:0] and the previous one in [15:8]. This lets downstream display and synth logic detect make codes, and break codes (8'hF0 followed by a code), directly. The block sits between the board PS/2 pins and every consumer of `key_press`.

## Interface
- `FILTER_LEN`, default 8: consecutive identical ps2_clk samples (after synchronisation) required before the filtered clock changes state.
- `TIMEOUT_CYCLES`, default 5000: cycles allowed between filtered falling edges inside a frame (100 µs at 50 MHz).
- `clk`  in  1  system clock; the single clock domain.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `ps2_clk`  in  1  PS/2 clock pin; asynchronous to `clk`, idles high.
- `ps2_data`  in  1  PS/2 data pin; asynchronous to `clk`, idles high.
- `key_press`  out  16  [7:0] last received byte, [15:8] byte before it.
- `key_valid`  out  1  one-cycle pulse when `key_press` takes a new byte.
- `parity_err`  out  1  one-cycle pulse when a frame is dropped for bad parity.
- `frame_err`  out  1  one-cycle pulse when a frame is dropped for bad stop bit or timeout.

## Operation
- Reset values:
  - `key_press` = 16'h0000.
  - `key_valid`, `parity_err`, `frame_err` = 0.
  - Synchroniser flops and filtered clock = 1.
  - State = IDLE; bit counter, shift register and timeout counter = 0.
- Synchronisation: two-flop synchronisers on both `ps2_clk` and `ps2_data`.
- Glitch filter:
  - Counts consecutive cycles in which the synchronised `ps2_clk` differs from the filtered value.
  - When the count reaches `FILTER_LEN`, the filtered value toggles and the count clears.
  - Any cycle where the two agree clears the count.
- Sample event: a cycle in which the filtered clock is 0 and its previous-cycle value is 1. On that cycle the synchronised `ps2_data` is sampled.
- State machine:
  - IDLE: on a sample with data=0 (start bit), go to DATA, clear the bit counter. A sample with data=1 is ignored.
  - DATA: each sample shifts data into the MSB of the shift register (LSB-first on the wire). After the 8th sample, go to PARITY.
  - PARITY: the sample is stored. Parity is OK when the XOR of the 8 data bits and the parity bit = 1 (odd). Go to STOP.
  - STOP, stop bit = 0: pulse `frame_err`, drop the frame.
  - STOP, stop bit = 1 and parity bad: pulse `parity_err`, drop the frame.
  - STOP, stop bit = 1 and parity OK: `key_press` <= {`key_press`[7:0], byte}, pulse `key_valid`.
  - STOP always returns to IDLE.
- Timeout:
  - In DATA/PARITY/STOP, the counter increments every cycle without a sample event and clears on each sample event.
  - On reaching `TIMEOUT_CYCLES`: go to IDLE, pulse `frame_err`, leave `key_press` unchanged.
  - In IDLE the counter is held at 0.
- Bad stop bit and bad parity together: only `frame_err` pulses.
- At most one of `key_valid`, `parity_err`, `frame_err` is high in any cycle.
- `key_press` holds its value between valid frames. There is no break-code interpretation inside this block.
- `rst_n` low mid-frame: all state returns to reset values immediately. The partial frame is discarded. After release, reception resumes at the next start bit.

## Timing
- Pin-to-sample latency: a `ps2_clk` falling edge at the pin produces the sample event exactly `FILTER_LEN`+2 cycles later, given a clean edge and stable `ps2_data`.
- Output timing: the sample event for the stop bit (or for the timeout) updates `key_press` and pulses the status output on the next `clk` rising edge. Total pin-to-output latency is `FILTER_LEN`+3 cycles.
- Pulse width: every status pulse is exactly 1 cycle.
- `ps2_clk` pulses shorter than `FILTER_LEN` cycles (either polarity) produce no sample event.
- Back-to-back frames need no idle gap beyond the stop bit. A start bit sampled on the first sample event after STOP is accepted.

## Test plan
- Single frame: send 0x1C (data 0,0,1,1,1,0,0,0 LSB-first, parity 0, stop 1) from reset → `key_press`=16'h001C, one `key_valid` pulse `FILTER_LEN`+3 cycles after the stop-bit fall, no error pulses.
- Break sequence: frames 0x1C, 0xF0, 0x1C → `key_press` reads 16'h001C, 16'h1CF0, 16'hF01C, with three `key_valid` pulses.
- Parity error: frame 0x25 with parity bit 1 → one `parity_err` pulse, no `key_valid`, `key_press` unchanged. The next good frame 0x25 gives [7:0]=8'h25.
- Timeout and stop error:
  - Stop clocking after 4 data bits for `TIMEOUT_CYCLES`+10 cycles → one `frame_err` pulse; a following 0x16 frame is received correctly.
  - Stop bit 0 → `frame_err` pulse only.
- Glitch rejection: with `FILTER_LEN`=8, insert 3-cycle low pulses on `ps2_clk` between the real edges of frame 0x1E → `key_press`[7:0]=8'h1E, no errors.
- Reset mid-frame: assert `rst_n` low after 5 data bits → outputs at reset values within the same cycle. After release, a full 0x1B frame gives `key_press`=16'h001B.

Source files
------------

// File: rtl/ps2_keyboard.sv
// rtl/ps2_keyboard.sv - PS/2 keyboard receiver producing a two-byte scan-code history
module ps2_keyboard #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] key_press,
    output logic        key_valid,
    output logic        parity_err,
    output logic        frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    logic          clk_s1_q, clk_s2_q;
    logic          dat_s1_q, dat_s2_q;
    logic          filt_q, filt_prev_q;
    logic [FW-1:0] filt_cnt_q;

    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [15:0]   key_press_q, key_press_d;
    logic          key_valid_q, key_valid_d;
    logic          parity_err_q, parity_err_d;
    logic          frame_err_q, frame_err_d;

    logic          sample;
    logic          timeout;

    // Synchronise both pins and debounce the clock: it must disagree with the
    // filtered value for FILTER_LEN cycles in a row before the filter follows it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1_q    <= 1'b1;
            clk_s2_q    <= 1'b1;
            dat_s1_q    <= 1'b1;
            dat_s2_q    <= 1'b1;
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
            filt_cnt_q  <= '0;
        end else begin
            clk_s1_q    <= ps2_clk;
            clk_s2_q    <= clk_s1_q;
            dat_s1_q    <= ps2_data;
            dat_s2_q    <= dat_s1_q;
            filt_prev_q <= filt_q;
            if (clk_s2_q != filt_q) begin
                if (filt_cnt_q == FILT_LAST) begin
                    filt_q     <= ~filt_q;
                    filt_cnt_q <= '0;
                end else begin
                    filt_cnt_q <= filt_cnt_q + 1'b1;
                end
            end else begin
                filt_cnt_q <= '0;
            end
        end
    end

    // Data is taken on the falling edge of the filtered clock; the timeout only
    // fires on a cycle that carries no sample, so a late edge still wins.
    assign sample  = filt_prev_q & ~filt_q;
    assign timeout = (state_q != ST_IDLE) && !sample && (tmo_cnt_q == TMO_LAST);

    // Frame state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame sequencing: start, eight data bits, parity, stop.
    always_comb begin
        state_d = state_q;
        if (timeout) begin
            state_d = ST_IDLE;
        end else if (sample) begin
            case (state_q)
                ST_IDLE:   if (!dat_s2_q) state_d = ST_DATA;
                ST_DATA:   if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
                ST_PARITY: state_d = ST_STOP;
                ST_STOP:   state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Datapath and status pulses: shift in LSB-first, check odd parity and the
    // stop bit, and push accepted bytes into the two-byte history.
    always_comb begin
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        parity_d     = parity_q;
        key_press_d  = key_press_q;
        key_valid_d  = 1'b0;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;

        if (state_q == ST_IDLE || sample || timeout) begin
            tmo_cnt_d = '0;
        end else begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end

        if (timeout) begin
            frame_err_d = 1'b1;
        end else if (sample) begin
            case (state_q)
                ST_IDLE: begin
                    bit_cnt_d = 3'd0;
                end
                ST_DATA: begin
                    shift_d   = {dat_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
                ST_PARITY: begin
                    parity_d = dat_s2_q;
                end
                ST_STOP: begin
                    if (!dat_s2_q) begin
                        frame_err_d = 1'b1;
                    end else if (!(^{shift_q, parity_q})) begin
                        parity_err_d = 1'b1;
                    end else begin
                        key_press_d = {key_press_q[7:0], shift_q};
                        key_valid_d = 1'b1;
                    end
                end
                default: begin
                    bit_cnt_d = 3'd0;
                end
            endcase
        end
    end

    // Datapath and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            parity_q     <= 1'b0;
            tmo_cnt_q    <= '0;
            key_press_q  <= 16'h0000;
            key_valid_q  <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            tmo_cnt_q    <= tmo_cnt_d;
            key_press_q  <= key_press_d;
            key_valid_q  <= key_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign key_press  = key_press_q;
    assign key_valid  = key_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_keyboard.sv
// tb/tb_ps2_keyboard.sv - self-checking bench for ps2_keyboard
module tb_ps2_keyboard;

    localparam int FLEN = 8;
    localparam int TMO  = 5000;
    localparam int HALF = 30;

    logic        clk;
    logic        rst_n;
    logic        ps2_clk_r;
    logic        ps2_data_r;
    logic [15:0] key_press;
    logic        key_valid;
    logic        parity_err;
    logic        frame_err;

    int checks   = 0;
    int failures = 0;

    int v_cnt = 0, p_cnt = 0, f_cnt = 0, multi_cnt = 0;
    int exp_v = 0, exp_p = 0, exp_f = 0;
    logic [15:0] exp_kp = 16'h0000;

    ps2_keyboard #(.FILTER_LEN(FLEN), .TIMEOUT_CYCLES(TMO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk_r),
        .ps2_data  (ps2_data_r),
        .key_press (key_press),
        .key_valid (key_valid),
        .parity_err(parity_err),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            v_cnt += int'(key_valid);
            p_cnt += int'(parity_err);
            f_cnt += int'(frame_err);
            if (int'(key_valid) + int'(parity_err) + int'(frame_err) > 1) multi_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One wire bit: data changes mid high phase, then a full low phase.
    task automatic send_bit(input logic b, input logic glitch, output int lat);
        @(negedge clk);
        ps2_data_r = b;
        repeat (HALF / 2) @(negedge clk);
        if (glitch) begin
            ps2_clk_r = 1'b0;
            repeat (3) @(negedge clk);
            ps2_clk_r = 1'b1;
        end
        repeat (HALF / 2) @(negedge clk);
        ps2_clk_r = 1'b0;
        lat = 0;
        for (int i = 1; i <= HALF; i++) begin
            @(posedge clk);
            #1;
            if (lat == 0 && (key_valid || parity_err || frame_err)) lat = i;
            if (glitch && i == 16) ps2_clk_r = 1'b1;
            if (glitch && i == 19) ps2_clk_r = 1'b0;
        end
        @(negedge clk);
        ps2_clk_r = 1'b1;
    endtask

    // Reference: what a frame must do to the observable outputs.
    task automatic model_frame(input logic [7:0] b, input logic p, input logic stop_b);
        if (!stop_b) exp_f++;
        else if ((^b ^ p) != 1'b1) exp_p++;
        else begin
            exp_v++;
            exp_kp = {exp_kp[7:0], b};
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic pflip, input logic stop_b,
                              input logic glitch, output int lat);
        int   l;
        logic p;
        p = ~(^b) ^ pflip;
        send_bit(1'b0, glitch, l);
        for (int i = 0; i < 8; i++) send_bit(b[i], glitch, l);
        send_bit(p, glitch, l);
        send_bit(stop_b, glitch, lat);
        ps2_data_r = 1'b1;
        model_frame(b, p, stop_b);
    endtask

    task automatic check_all(input string tag);
        repeat (5) @(negedge clk);
        check({tag, ".key_press"}, 32'(key_press), 32'(exp_kp));
        check({tag, ".valid_cnt"}, v_cnt, exp_v);
        check({tag, ".perr_cnt"}, p_cnt, exp_p);
        check({tag, ".ferr_cnt"}, f_cnt, exp_f);
    endtask

    initial begin
        int          lat;
        logic [7:0]  rb;
        logic        rp, rs, rg;

        rst_n      = 1'b0;
        ps2_clk_r  = 1'b1;
        ps2_data_r = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset.key_press", 32'(key_press), 32'h0);
        check("reset.pulses", {29'd0, key_valid, parity_err, frame_err}, 32'h0);

        send_frame(8'h1C, 1'b0, 1'b1, 1'b0, lat);
        check("single.latency", lat, FLEN + 3);
        check_all("single");

        send_frame(8'hF0, 1'b0, 1'b1, 1'b0, lat);
        check_all("break_f0");
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0, lat);
        check_all("break_1c");

        send_frame(8'h25, 1'b1, 1'b1, 1'b0, lat);
        check_all("parity_bad");
        send_frame(8'h25, 1'b0, 1'b1, 1'b0, lat);
        check_all("parity_good");

        send_bit(1'b0, 1'b0, lat);
        for (int i = 0; i < 4; i++) send_bit(i[0], 1'b0, lat);
        ps2_data_r = 1'b1;
        repeat (TMO + 10) @(negedge clk);
        exp_f++;
        check_all("timeout");
        send_frame(8'h16, 1'b0, 1'b1, 1'b0, lat);
        check_all("after_timeout");

        send_frame(8'h3A, 1'b0, 1'b0, 1'b0, lat);
        check_all("stop_bad");
        send_frame(8'h5B, 1'b1, 1'b0, 1'b0, lat);
        check_all("stop_and_parity_bad");

        send_frame(8'h1E, 1'b0, 1'b1, 1'b1, lat);
        check_all("glitch");

        send_frame(8'h12, 1'b0, 1'b1, 1'b0, lat);
        send_frame(8'h34, 1'b0, 1'b1, 1'b0, lat);
        check_all("back_to_back");

        for (int n = 0; n < 12; n++) begin
            rb = 8'($urandom);
            rp = ($urandom_range(0, 3) == 0);
            rs = ($urandom_range(0, 5) != 0);
            rg = 1'($urandom);
            send_frame(rb, rp, rs, rg, lat);
            check_all("random");
        end

        send_bit(1'b0, 1'b0, lat);
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0, lat);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset.key_press", 32'(key_press), 32'h0);
        check("midreset.pulses", {29'd0, key_valid, parity_err, frame_err}, 32'h0);
        exp_kp     = 16'h0000;
        ps2_data_r = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        send_frame(8'h1B, 1'b0, 1'b1, 1'b0, lat);
        check_all("after_reset");

        check("exclusive_pulses", multi_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
